// File: rtl/relu_writer_pkg.sv
// Shared definitions for the layer-0 ReLU write-back stage: data width,
// memory-select codes and the write-back FSM state encodings.
package relu_writer_pkg;

  localparam int INTERNAL_BITS = 32;

  localparam logic [2:0] MEM_SEL_NONE = 3'b000;
  localparam logic [2:0] MEM_SEL_L0   = 3'b001;
  localparam logic [2:0] MEM_SEL_L1   = 3'b010;
  localparam logic [2:0] MEM_SEL_L2   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_t;

endpackage

// File: rtl/relu_writer_stage.sv
// Building blocks of the write-back stage: the combinational ReLU and the
// 2-entry buffer that absorbs memory stalls.
module Relu #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Negative values (sign bit set) clamp to zero; everything else passes through.
  assign dout = din[DATA_W-1] ? '0 : din;

endmodule

module skid_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic [1:0]        count_next
);

  logic [DATA_W-1:0] entry [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

  assign head  = entry[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/relu_writer.sv
// Streaming ReLU write-back: accepts accumulator results, activates them and
// writes one frame into the layer result memory in raster order.
module relu_writer
  import relu_writer_pkg::*;
#(
  parameter int         DATA_W  = INTERNAL_BITS,
  parameter int         IMG_W   = 64,
  parameter int         IMG_H   = 64,
  parameter int         ADDR_W  = 12,
  parameter logic [2:0] MEM_SEL = MEM_SEL_L0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              mem_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [2:0]        mem_sel,
  output logic              busy,
  output logic              done
);

  localparam int                TOTAL     = IMG_W * IMG_H;
  localparam int                CNT_W     = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(TOTAL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  wr_state_t         state;
  wr_state_t         state_next;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  acc_next;
  logic [ADDR_W-1:0] pix_cnt;
  logic              ready_next;

  logic              push;
  logic              issue;
  logic              last_issue;
  logic              start_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [1:0]        fifo_count_next;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] relu_data;
  logic [DATA_W-1:0] wr_data;

  Relu #(.DATA_W(DATA_W)) u_relu (
    .din  (in_data),
    .dout (relu_data)
  );

  // When the buffer is empty the incoming value goes straight to memory, so an
  // unstalled stream sees one-cycle latency and never occupies the buffer.
  assign push       = in_valid && in_ready;
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign issue      = (state == ST_RUN) && !mem_stall && (!fifo_empty || push);
  assign last_issue = issue && (pix_cnt == LAST_ADDR);
  assign fifo_pop   = issue && !fifo_empty;
  assign fifo_push  = push && !(issue && fifo_empty);
  assign wr_data    = fifo_empty ? relu_data : fifo_head;

  skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (relu_data),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .count_next (fifo_count_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (last_issue) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_DONE;
      ST_DONE:  if (start) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // in_ready is registered, so it looks ahead at next-cycle occupancy and count.
  always_comb begin
    acc_next = acc_cnt;
    if (start_ok) begin
      acc_next = '0;
    end else if (push) begin
      acc_next = acc_cnt + CNT_W'(1);
    end
    ready_next = (state_next == ST_RUN) && (fifo_count_next < 2'd2) && (acc_next < TOTAL_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt  <= '0;
      pix_cnt  <= '0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_sel  <= 3'b000;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      acc_cnt  <= acc_next;
      in_ready <= ready_next;
      if (start_ok) begin
        pix_cnt <= '0;
      end else if (issue && (pix_cnt != LAST_ADDR)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      mem_we  <= issue;
      mem_sel <= issue ? MEM_SEL : 3'b000;
      if (issue) begin
        mem_addr <= pix_cnt;
        mem_data <= wr_data;
      end
      busy <= (state_next == ST_RUN) || (state_next == ST_FLUSH);
      done <= (state == ST_FLUSH);
    end
  end

endmodule

// File: tb/tb_relu_writer.sv
// Self-checking bench for relu_writer: table-driven ReLU vectors, full frames
// with a scoreboard of expected writes, plus stall, restart and reset sequences.
module tb_relu_writer;

  localparam int         DATA_W = 32;
  localparam int         IMG_W  = 64;
  localparam int         IMG_H  = 64;
  localparam int         ADDR_W = 12;
  localparam int         TOTAL  = IMG_W * IMG_H;
  localparam logic [2:0] SEL    = 3'b001;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              mem_stall = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [2:0]        mem_sel;
  logic              busy;
  logic              done;

  int   compared = 0;
  int   mismatched = 0;
  int   acc_idx = 0;
  int   write_count = 0;
  int   done_count = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[10];

  always #5 clk = ~clk;

  relu_writer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .MEM_SEL(SEL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_stall(mem_stall),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_sel  (mem_sel),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [DATA_W-1:0] reluModel(input logic [DATA_W-1:0] x);
    return ($signed(x) < 0) ? '0 : x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  task automatic finishRun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  // Drive one value and hold it until the DUT accepts it; the scoreboard entry
  // is pushed when the handshake is certain (in_ready seen high before the edge).
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %0b, expected 1 within 100 cycles", in_ready);
      finishRun();
    end
    exp_q.push_back('{ADDR_W'(acc_idx), e});
    acc_idx++;
    @(negedge clk);
  endtask

  task automatic startFrame(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc_idx = 0;
    checkOutput({tag, "_ready_after_start"}, in_ready, 1);
    checkOutput({tag, "_busy_after_start"}, busy, 1);
  endtask

  task automatic waitDone(input string tag);
    int   extra = 0;
    int   wc;
    logic prev_we = 1'b0;
    bit   seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (in_valid && in_ready) extra++;
      if (done) begin
        seen = 1'b1;
        checkOutput({tag, "_we_before_done"}, prev_we, 1);
        checkOutput({tag, "_we_at_done"}, mem_we, 0);
        checkOutput({tag, "_busy_at_done"}, busy, 0);
        checkOutput({tag, "_scoreboard_drained"}, exp_q.size(), 0);
      end
      prev_we = mem_we;
      @(negedge clk);
    end
    checkOutput({tag, "_done_seen"}, seen, 1);
    checkOutput({tag, "_done_one_cycle"}, done, 0);
    #1;
    wc = write_count;
    repeat (10) begin
      if (in_valid && in_ready) extra++;
      @(negedge clk);
    end
    checkOutput({tag, "_extra_accepts"}, extra, 0);
    checkOutput({tag, "_trailing_writes"}, write_count - wc, 0);
    in_valid = 1'b0;
  endtask

  // Write monitor: every mem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      write_count++;
      checkOutput("scoreboard_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", mem_addr, mon_e.addr);
        checkOutput("wr_data", mem_data, mon_e.data);
        checkOutput("wr_sel", mem_sel, SEL);
      end
    end
    if (reset && done) done_count++;
  end

  initial begin
    #1_000_000;
    compared++;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    finishRun();
  end

  initial begin
    int ready_seen;
    int accepted;
    int wb;
    int dc;
    logic [DATA_W-1:0] v;

    vecs[0] = '{32'd5,        32'd5};
    vecs[1] = '{32'hFFFFFFFB, 32'd0};
    vecs[2] = '{32'd5,        32'd5};
    vecs[3] = '{32'hFFFFFFFB, 32'd0};
    vecs[4] = '{32'h80000000, 32'd0};
    vecs[5] = '{32'h7FFFFFFF, 32'h7FFFFFFF};
    vecs[6] = '{32'h00000000, 32'd0};
    vecs[7] = '{32'hFFFFFFFF, 32'd0};
    vecs[8] = '{32'h00000001, 32'd1};
    vecs[9] = '{32'h40000000, 32'h40000000};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_data", mem_data, 0);
    checkOutput("rst_mem_sel", mem_sel, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    // in_valid in IDLE is never accepted
    ready_seen = 0;
    in_valid = 1'b1;
    in_data  = 32'd123;
    repeat (6) begin
      if (in_ready) ready_seen++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("idle_in_ready", ready_seen, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_writes", write_count, 0);

    // Frame 1: values 0..TOTAL-1 back to back, with a mid-frame start
    $display("[TB] frame 1: ramp with mid-frame start");
    startFrame("f1");
    applyStimulus(32'd0, 32'd0);
    checkOutput("f1_first_write_latency", mem_we, 1);
    for (int i = 1; i < TOTAL; i++) begin
      if (i == 1000) start = 1'b1;
      applyStimulus(DATA_W'(i), DATA_W'(i));
      start = 1'b0;
    end
    in_data = DATA_W'(TOTAL);
    waitDone("f1");
    checkOutput("f1_write_count", write_count, TOTAL);

    // Frame 2: restart after done, ReLU table, stall, then fill
    $display("[TB] frame 2: relu table and stall");
    startFrame("f2");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].din, vecs[i].exp);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    wb = write_count;
    mem_stall = 1'b1;
    in_valid  = 1'b1;
    accepted  = 0;
    in_data   = 32'hFFFF0000;
    for (int k = 0; k < 3; k++) begin
      if (in_ready) begin
        exp_q.push_back('{ADDR_W'(acc_idx), reluModel(in_data)});
        acc_idx++;
        accepted++;
      end
      @(negedge clk);
      in_data = (accepted == 1) ? 32'd777 : 32'd888;
    end
    checkOutput("stall_accepts", accepted, 2);
    checkOutput("stall_in_ready", in_ready, 0);
    checkOutput("stall_no_writes", write_count - wb, 0);
    mem_stall = 1'b0;
    @(negedge clk);
    checkOutput("stall_resume_latency", mem_we, 1);
    while (acc_idx < TOTAL) begin
      v = DATA_W'(acc_idx * 37 - 2000);
      applyStimulus(v, reluModel(v));
    end
    waitDone("f2");

    // Frame 3: asynchronous reset with two entries buffered at pixel 100
    $display("[TB] frame 3: reset mid-frame");
    startFrame("f3");
    for (int i = 0; i < 100; i++) begin
      v = DATA_W'(i * 11 - 300);
      applyStimulus(v, reluModel(v));
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    mem_stall = 1'b1;
    applyStimulus(32'd5001, 32'd5001);
    applyStimulus(32'd5002, 32'd5002);
    in_valid = 1'b0;
    #2;
    dc = done_count;
    reset = 1'b0;
    #1;
    checkOutput("arst_in_ready", in_ready, 0);
    checkOutput("arst_mem_we", mem_we, 0);
    checkOutput("arst_mem_addr", mem_addr, 0);
    checkOutput("arst_mem_data", mem_data, 0);
    checkOutput("arst_mem_sel", mem_sel, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    exp_q.delete();
    mem_stall = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("arst_no_done", done_count - dc, 0);
    checkOutput("arst_idle_ready", in_ready, 0);

    // Frame 4: fresh start after reset writes from address 0, random data
    $display("[TB] frame 4: random data after reset");
    startFrame("f4");
    while (acc_idx < TOTAL) begin
      v = $urandom;
      applyStimulus(v, reluModel(v));
    end
    waitDone("f4");

    finishRun();
  end

endmodule
